// File: rtl/reg_dump_scanner_if.sv
// Beat stream carrying {index, value} pairs out of the register dump unit.
interface reg_dump_scanner_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data;

  modport master (output valid, idx, data, input ready);
  modport slave  (input valid, idx, data, output ready);
endinterface

// File: rtl/reg_dump_scanner.sv
// Register-file dump unit: walks r0..r(NUM_REGS-1) through a combinational read
// port and streams {index, value} beats over a valid/ready interface. A one-shot
// auto-dump fires END_COUNT cycles after reset; start_i requests a dump on demand.
module reg_dump_scanner #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 13,
  parameter int END_COUNT = 25
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic [ADDR_W-1:0]   rf_addr_o,
  input  logic [DATA_W-1:0]   rf_data_i,
  reg_dump_scanner_if.master  dump,
  output logic                busy_o,
  output logic                done_o
);

  localparam int                CNT_W      = (END_COUNT < 1) ? 1 : $clog2(END_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_END    = CNT_W'(END_COUNT);
  // One extra bit so a full 2**ADDR_W walk ends on NUM_REGS instead of wrapping to 0.
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cycle_cnt;
  logic             auto_fired;
  logic [ADDR_W:0]  issue_idx;

  logic auto_trig;
  logic trigger;
  logic advance;
  logic last;

  // Auto trigger and manual start are merged so a coincident pair yields one dump.
  assign auto_trig = (cycle_cnt == CNT_END) && !auto_fired && (state == IDLE);
  assign trigger   = (state == IDLE) && (start_i || auto_trig);
  // The output slot is free when empty or being drained this cycle.
  assign advance   = (state == SCAN) && (!dump.valid || dump.ready);
  assign last      = (issue_idx == NUM_REGS_W);

  assign rf_addr_o = (state == SCAN) ? issue_idx[ADDR_W-1:0] : '0;
  assign busy_o    = (state == SCAN);
  assign done_o    = (state == DONE);

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode: IDLE waits for a trigger, SCAN ends when the last beat
  // drains, DONE lasts exactly one cycle.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (trigger)         state_next = SCAN;
      SCAN:    if (advance && last) state_next = DONE;
      DONE:                         state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Post-reset cycle counter (saturating) and the one-shot auto-dump flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt  <= '0;
      auto_fired <= 1'b0;
    end else begin
      if (cycle_cnt != CNT_END) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (auto_trig)            auto_fired <= 1'b1;
    end
  end

  // Beat register: snapshot the read data at load time and hold it under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_idx  <= '0;
      dump.valid <= 1'b0;
      dump.idx   <= '0;
      dump.data  <= '0;
    end else if (trigger) begin
      issue_idx  <= '0;
      dump.valid <= 1'b0;
    end else if (advance) begin
      if (!last) begin
        dump.data  <= rf_data_i;
        dump.idx   <= issue_idx[ADDR_W-1:0];
        dump.valid <= 1'b1;
        issue_idx  <= issue_idx + (ADDR_W + 1)'(1);
      end else begin
        dump.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Self-checking bench for reg_dump_scanner: scenario table, randomized ready/data
// runs against a beat-list reference model, and hand-written snapshot/reset sequences.
module tb_reg_dump_scanner;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int NUM_REGS  = 13;
  localparam int END_COUNT = 25;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] rf     [2**ADDR_W];
  logic [DATA_W-1:0] exp_rf [NUM_REGS];

  int   ready_mode   = 0;   // 0 always, 1 pattern 1,0,0,1, 2 random, 3 manual
  logic ready_manual = 1'b0;
  logic ready_auto   = 1'b1;

  reg_dump_scanner_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dump_bus ();

  reg_dump_scanner #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .END_COUNT(END_COUNT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .rf_addr_o (rf_addr),
    .rf_data_i (rf_data),
    .dump      (dump_bus.master),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  assign rf_data        = rf[rf_addr];
  assign dump_bus.ready = (ready_mode == 3) ? ready_manual : ready_auto;

  // Cycles since reset release: cycle k is the interval after the k-th non-reset edge.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Ready generator, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       case (cyc % 4) 0, 3: ready_auto = 1'b1; default: ready_auto = 1'b0; endcase
      2:       ready_auto = ($urandom_range(0, 3) != 0);
      default: ready_auto = 1'b1;
    endcase
  end

  // Mid-cycle monitor: collects accepted beats, done pulses and stall stability.
  int   first_valid, dones, done_first, acc_n, acc_last, stall_cycles, stall_bad;
  logic held;
  logic [ADDR_W-1:0] held_idx;
  logic [DATA_W-1:0] held_data;
  logic [ADDR_W-1:0] got_idx [$];
  logic [DATA_W-1:0] got_data [$];

  always @(negedge clk) begin
    if (rst) begin
      first_valid = -1; dones = 0; done_first = -1; acc_n = 0; acc_last = -1;
      stall_cycles = 0; stall_bad = 0; held = 1'b0;
      got_idx.delete(); got_data.delete();
    end else begin
      if (held) begin
        stall_cycles++;
        if (!(dump_bus.valid && dump_bus.idx == held_idx && dump_bus.data == held_data))
          stall_bad++;
      end
      if (dump_bus.valid && first_valid < 0) first_valid = cyc;
      if (dump_bus.valid && dump_bus.ready) begin
        got_idx.push_back(dump_bus.idx);
        got_data.push_back(dump_bus.data);
        acc_n++;
        if (acc_n == NUM_REGS) acc_last = cyc;
      end
      if (done) begin
        dones++;
        if (done_first < 0) done_first = cyc;
      end
      held      = dump_bus.valid && !dump_bus.ready;
      held_idx  = dump_bus.idx;
      held_data = dump_bus.data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rf(input bit random_data);
    for (int i = 0; i < 2**ADDR_W; i++)
      rf[i] = random_data ? $urandom : DATA_W'(i * 3);
    for (int i = 0; i < NUM_REGS; i++) exp_rf[i] = rf[i];
  endtask

  // One reset cycle; leaves cyc == 0 with the DUT just out of reset.
  task automatic do_reset();
    step();
    rst = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
    check("reset_state",
          {dump_bus.valid, busy, done, rf_addr, dump_bus.idx, dump_bus.data}, 64'd0);
  endtask

  task automatic run_window(input int window, input int start_at, input int pulse_at);
    for (int c = 1; c <= window; c++) begin
      step();
      start = (c == start_at) || (c == pulse_at);
    end
    start = 1'b0;
  endtask

  // Reference model: each dump is the list r0..r(NUM_REGS-1) with its snapshot value.
  task automatic check_beats(input string name, input int dumps);
    int n;
    check({name, "_beat_count"}, got_idx.size(), dumps * NUM_REGS);
    n = (got_idx.size() < dumps * NUM_REGS) ? got_idx.size() : dumps * NUM_REGS;
    for (int k = 0; k < n; k++)
      check({name, "_beat"}, {got_idx[k], got_data[k]},
            {ADDR_W'(k % NUM_REGS), exp_rf[k % NUM_REGS]});
  endtask

  task automatic eval_run(input string name, input int exp_first, input int exp_dumps);
    check({name, "_first_valid"}, first_valid, exp_first);
    check({name, "_dones"}, dones, exp_dumps);
    check({name, "_done_after_last"}, done_first, acc_last + 1);
    check({name, "_stall_hold"}, stall_bad, 0);
    check_beats(name, exp_dumps);
  endtask

  typedef struct {
    string name;
    int    start_at;    // cycle with start_i high, -1 for none
    int    pulse_at;    // extra start_i pulse expected to be ignored, -1 for none
    int    ready_mode;
    int    exp_first;   // cycle the first beat becomes valid
    int    exp_dumps;   // full dumps expected inside the window
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{"auto",         -1, -1, 0, 27, 1};
    vecs[1] = '{"backpressure", -1, -1, 1, 27, 1};
    vecs[2] = '{"manual_scan",   5, 12, 0,  7, 2};
    vecs[3] = '{"manual_done",   5, 20, 0,  7, 2};
    vecs[4] = '{"collision",    25, -1, 0, 27, 1};
    vecs[5] = '{"late_manual",  20, -1, 0, 22, 2};

    for (int v = 0; v < 6; v++) begin
      load_rf(1'b0);
      ready_mode = vecs[v].ready_mode;
      do_reset();
      run_window(100, vecs[v].start_at, vecs[v].pulse_at);
      eval_run(vecs[v].name, vecs[v].exp_first, vecs[v].exp_dumps);
      if (vecs[v].ready_mode == 0)
        check({vecs[v].name, "_done_cycle"}, done_first, vecs[v].exp_first + NUM_REGS);
      else
        check({vecs[v].name, "_stalls_seen"}, stall_cycles > 0, 1);
    end

    // Random data and random backpressure, auto-dump only.
    for (int it = 0; it < 3; it++) begin
      load_rf(1'b1);
      ready_mode = 2;
      do_reset();
      run_window(150, -1, -1);
      eval_run("random", END_COUNT + 2, 1);
    end

    // Snapshot: overwrite a register while its beat is stalled.
    load_rf(1'b0);
    ready_mode   = 3;
    ready_manual = 1'b0;
    do_reset();
    for (int c = 0; c < 60 && !dump_bus.valid; c++) step();
    check("snap_first", {dump_bus.valid, dump_bus.idx, dump_bus.data}, {1'b1, 5'd0, 32'd0});
    rf[0] = 32'hDEAD_BEEF;
    repeat (3) step();
    check("snap_hold0", {busy, dump_bus.valid, dump_bus.data}, {1'b1, 1'b1, 32'd0});
    ready_manual = 1'b1;
    step();
    ready_manual = 1'b0;
    check("snap_second", {dump_bus.valid, dump_bus.idx, dump_bus.data}, {1'b1, 5'd1, 32'd3});
    rf[1] = 32'h0000_BEEF;
    repeat (2) step();
    check("snap_hold1", dump_bus.data, 32'd3);
    ready_manual = 1'b1;
    for (int c = 0; c < 40 && dones == 0; c++) step();
    step();
    check("snap_dones", dones, 1);
    check("snap_stall_hold", stall_bad, 0);
    check_beats("snap", 1);

    // Reset in the middle of a dump, then a fresh full auto-dump.
    load_rf(1'b0);
    ready_mode = 0;
    do_reset();
    for (int c = 0; c < 60 && acc_n < 6; c++) step();
    check("mid_six_beats", acc_n, 6);
    rst = 1'b1;
    step();
    check("mid_reset_clear", {dump_bus.valid, busy, done}, 3'b000);
    rst = 1'b0;
    run_window(60, -1, -1);
    eval_run("mid_redump", END_COUNT + 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
